// File: rtl/complex_alu_ctrl_pkg.sv
// Shared types and constants for the complex ALU control path.
package complex_alu_ctrl_pkg;

  localparam int ALUMODE_W = 4;
  localparam int INMODE_W  = 5;
  localparam int OPMODE_W  = 9;

  // Instruction opcodes; the unlisted codes 001/010/011 are illegal.
  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_MULADD = 3'b101;
  localparam logic [2:0] OP_MULSUB = 3'b110;
  localparam logic [2:0] OP_MAX    = 3'b111;

  // DSP mode constants
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_NEGSUB = 4'b0011;
  localparam logic [8:0] OPM_M      = 9'h005;
  localparam logic [8:0] OPM_CM     = 9'h035;
  localparam logic [4:0] INM_DEF    = 5'b00000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPEAT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // One issued control word; per-DSP fields are packed DSP1 (MSBs) .. DSP4 (LSBs).
  typedef struct packed {
    logic [2:0]              alu_opcode;
    logic [4*ALUMODE_W-1:0]  alumode;
    logic [4*INMODE_W-1:0]   inmode;
    logic [4*OPMODE_W-1:0]   opmode;
    logic [3:0]              cea2;
    logic [3:0]              ceb2;
    logic [3:0]              usemult;
  } ctrl_word_t;

endpackage

// File: rtl/complex_alu_ctrl_decode.sv
// Combinational opcode -> control-word table, shared by PE variants.
module alu_op_decode
  import complex_alu_ctrl_pkg::*;
(
  input  logic [2:0]  opcode,
  output ctrl_word_t  word,
  output logic        legal,
  output logic        is_op
);

  logic legal_s;
  logic op_s;

  // Translate the opcode into per-DSP mode fields and legality flags
  always_comb begin
    word    = '0;
    legal_s = 1'b1;
    op_s    = 1'b1;
    case (opcode)
      OP_NOP: begin
        op_s = 1'b0;
      end
      OP_MUL, OP_MAX: begin
        word.alu_opcode = opcode;
        word.alumode    = {4{ALU_ADD}};
        word.opmode     = {4{OPM_M}};
      end
      OP_MULADD: begin
        word.alu_opcode = opcode;
        word.alumode    = {4{ALU_ADD}};
        word.opmode     = {OPM_CM, OPM_M, OPM_CM, OPM_M};
      end
      OP_MULSUB: begin
        word.alu_opcode = opcode;
        word.alumode    = {ALU_ADD, ALU_NEGSUB, ALU_ADD, ALU_ADD};
        word.opmode     = {OPM_CM, OPM_M, OPM_CM, OPM_M};
      end
      default: begin
        // Illegal codes go out as a NOP
        legal_s = 1'b0;
        op_s    = 1'b0;
      end
    endcase
    if (op_s) begin
      word.inmode  = {4{INM_DEF}};
      word.cea2    = 4'b1111;
      word.ceb2    = 4'b1111;
      word.usemult = 4'b1111;
    end else begin
      word.usemult = 4'b0000;
    end
  end

  assign legal = legal_s;
  assign is_op = op_s;

endmodule

// File: rtl/complex_alu_ctrl.sv
// Issue sequencer for the 4-DSP complex ALU: handshake, repeat issue,
// flush drain and in-flight tracking that times result_valid.
module complex_alu_ctrl
  import complex_alu_ctrl_pkg::*;
#(
  parameter int ALU_LATENCY = 6,
  parameter int RPT_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instr_opcode,
  input  logic [RPT_WIDTH-1:0]    instr_rpt,
  input  logic                    flush,
  output logic [2:0]              alu_opcode,
  output logic [4*ALUMODE_W-1:0]  alumode,
  output logic [4*INMODE_W-1:0]   inmode,
  output logic [4*OPMODE_W-1:0]   opmode,
  output logic [3:0]              cea2,
  output logic [3:0]              ceb2,
  output logic [3:0]              usemult,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    flush_done,
  output logic                    illegal_op
);

  localparam logic [RPT_WIDTH-1:0] RPT_ONE = RPT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [RPT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  ctrl_word_t              word_q, word_d;
  // issue_q marks a result-producing word currently on the outputs;
  // sr_q then ages it so the tail lines up with ALU dout.
  logic                    issue_q, issue_d;
  logic [ALU_LATENCY-1:0]  sr_q, sr_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    fdone_q, fdone_d;
  logic                    illegal_q, illegal_d;

  ctrl_word_t              dec_word_s;
  logic                    dec_legal_s;
  logic                    dec_is_op_s;
  logic                    accept_s;

  alu_op_decode u_decode (
    .opcode (instr_opcode),
    .word   (dec_word_s),
    .legal  (dec_legal_s),
    .is_op  (dec_is_op_s)
  );

  // A flush request in IDLE takes priority over a simultaneous instruction
  assign accept_s = instr_valid && ready_q && (state_q == ST_IDLE) && !flush;

  // Next-state, issue word and tracker update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    word_d       = '0;
    issue_d      = 1'b0;
    fdone_d      = 1'b0;
    illegal_d    = illegal_q;
    sr_d         = {sr_q[ALU_LATENCY-2:0], issue_q};
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          // Nothing left to drain: complete the flush immediately
          if (sr_d == '0) begin
            state_d = ST_IDLE;
            fdone_d = 1'b1;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (accept_s) begin
          word_d    = dec_word_s;
          issue_d   = dec_is_op_s;
          illegal_d = illegal_q | ~dec_legal_s;
          if (instr_rpt != '0) begin
            state_d = ST_REPEAT;
            cnt_d   = instr_rpt;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REPEAT: begin
        word_d       = word_q;
        issue_d      = issue_q;
        flush_pend_d = flush_pend_q | flush;
        if (cnt_q <= RPT_ONE) begin
          cnt_d = '0;
          if (flush_pend_q || flush) begin
            state_d      = ST_FLUSH;
            flush_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - RPT_ONE;
        end
      end
      ST_FLUSH: begin
        if (sr_d == '0) begin
          state_d = ST_IDLE;
          fdone_d = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE) || issue_d || (sr_d != '0);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      word_q       <= '0;
      issue_q      <= 1'b0;
      sr_q         <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      fdone_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      word_q       <= word_d;
      issue_q      <= issue_d;
      sr_q         <= sr_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      fdone_q      <= fdone_d;
      illegal_q    <= illegal_d;
    end
  end

  assign instr_ready  = ready_q;
  assign alu_opcode   = word_q.alu_opcode;
  assign alumode      = word_q.alumode;
  assign inmode       = word_q.inmode;
  assign opmode       = word_q.opmode;
  assign cea2         = word_q.cea2;
  assign ceb2         = word_q.ceb2;
  assign usemult      = word_q.usemult;
  assign result_valid = sr_q[ALU_LATENCY-1];
  assign busy         = busy_q;
  assign flush_done   = fdone_q;
  assign illegal_op   = illegal_q;

endmodule

// File: doc/complex_alu_ctrl.md
Name: complex_alu_ctrl

Overview:
- Instruction decoder and issue sequencer that drives the control side of the 4-DSP complex ALU.
- Accepts opcodes over a valid/ready handshake and expands each into per-DSP ALUMODE/INMODE/OPMODE/CEA2/CEB2/USEMULT words.
- Supports back-to-back repeat issue and a pipeline flush.
- Tracks in-flight operations so the PE knows exactly when ALU output data is valid.

Parameters:
- ALU_LATENCY, 6: cycles from control word on outputs to valid ALU dout.
- RPT_WIDTH, 4: width of repeat count field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller accepts instruction this cycle
- instr_opcode  in  3  000 NOP, 100 MUL, 101 MULADD, 110 MULSUB, 111 MAX; others illegal
- instr_rpt  in  RPT_WIDTH  issue the op rpt+1 times
- flush  in  1  pulse: drain ALU pipeline
- alu_opcode  out  3  opcode to ALU
- alumode  out  `ALUMODE_WIDTH*4  DSP1 in MSBs ... DSP4 in LSBs
- inmode  out  `INMODE_WIDTH*4  same ordering
- opmode  out  `OPMODE_WIDTH*4  same ordering
- cea2, ceb2, usemult  out  4 each  bit3=DSP1 ... bit0=DSP4
- result_valid  out  1  ALU dout valid this cycle
- busy  out  1  ops in flight or sequencer not IDLE
- flush_done  out  1  one-cycle pulse when drain completes
- illegal_op  out  1  sticky flag, cleared only by rst

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: all control words 0, alu_opcode 000, instr_ready 0 during rst and 1 the cycle after, result_valid/busy/flush_done/illegal_op 0, state IDLE, in-flight shift register cleared.
- Reset mid-operation discards all pending repeats and in-flight tracking.
- Handshake: accept when instr_valid && instr_ready at a clk edge. The decoded word appears on the outputs after that edge (edge k).
- Decode table (ALUMODE, OPMODE hex per DSP 1..4):
  - NOP: all words 0; cea2=ceb2=usemult=0000.
  - MUL: alumode 0 all; opmode 005 all.
  - MULADD: alumode 0 all; opmode 035,005,035,005.
  - MULSUB: alumode 0,3,0,0; opmode 035,005,035,005.
  - MAX: alumode 0 all; opmode 005 all.
  - For every non-NOP op: inmode 00000 all; cea2=ceb2=usemult=1111.
- Illegal opcode: issued as NOP, sets illegal_op, no result_valid.
- FSM states:
  - IDLE: instr_ready=1.
    - Accept with rpt=0 -> stay IDLE.
    - Accept with rpt>0 -> REPEAT, with counter=rpt.
  - REPEAT: instr_ready=0; re-issue the same word every cycle and decrement the counter. At counter==1, the last issue occurs and the FSM returns to IDLE.
  - FLUSH: instr_ready=0; drive NOP words. Return to IDLE and pulse flush_done on the cycle the in-flight register becomes all-zero.
- flush sampled in IDLE: enter FLUSH; a simultaneous instr_valid is not accepted.
- flush sampled in REPEAT: complete all remaining repeats first, then enter FLUSH. The request is latched.
- flush with nothing in flight: flush_done pulses the following cycle.
- In-flight tracking: ALU_LATENCY-deep shift register; a 1 enters for each non-NOP, legal word issued. result_valid is the register tail, high exactly ALU_LATENCY cycles after the word first appears on the outputs.
- busy = (state != IDLE) || (shift register nonzero).
- Back-to-back issue: one op per cycle, no bubbles, including alternating opcodes.

Decomposition:
- Opcode localparams and DSP mode constants (ALU_ADD=4'b0000, ALU_NEGSUB=4'b0011, OPM_M=9'h005, OPM_CM=9'h035) go in the shared parameters.vh, alongside the existing width macros.
- One sub-module, alu_op_decode: a purely combinational opcode -> control-word table, reusable by other PE variants. The FSM, repeat counter and in-flight tracker stay in the top.

Test Plan:
- Reset then single MUL at cycle 2:
  - opmode = {4{9'h005}}, usemult=1111 on the next cycle.
  - result_valid is a single pulse 6 cycles later.
  - busy falls the cycle after.
- MULSUB with rpt=3:
  - instr_ready low for 3 cycles.
  - 4 consecutive identical words with alumode=0x0300.
  - 4 consecutive result_valid pulses.
- Stream MUL, MULADD, MAX, MULSUB on consecutive cycles:
  - words change every cycle per the decode table.
  - result_valid high for 4 consecutive cycles.
- Opcode 010 offered:
  - outputs NOP, illegal_op rises and stays high.
  - no result_valid.
  - illegal_op clears only on rst.
- flush asserted during rpt=2 MUL:
  - repeats finish, then NOPs are driven.
  - flush_done pulses the cycle the last result_valid drops; instr_ready then rises.
- rst asserted with 3 ops in flight:
  - the next cycle shows all outputs zero and no result_valid afterwards.
